alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU.
- All single-cycle operations are supported with registered outputs. Adds an iterative shift-add multiplier and registered flags.
- Sits in the EX stage. The pipeline stalls on in_ready low; results are consumed on out_valid/out_ready.

Parameters:
- WIDTH, 16, datapath width in bits (power of 2, 8..64).
- SHW, $clog2(WIDTH), shift-amount width taken from inputB[SHW-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/mode valid.
- in_ready  out  1  block can accept an operation this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- invA  in  1  use ~A (+c_in) as inputA.
- invB  in  1  use ~B (+c_in) as inputB.
- c_in  in  1  increment applied to each inverted operand.
- alu_mode  in  4  operation select.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- ZF, SF, OF, CF  out  1 each  flags of the held result.
- busy  out  1  multiplier iterating.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out=0, ZF=SF=OF=CF=0, out_valid=0, busy=0. Reset mid-multiply aborts it with no output.
- Operand prep:
  - inputA = invA ? (~A + c_in) : A; likewise inputB. All arithmetic is mod 2^WIDTH.
- Modes:
  - 0 ADD: inputA+inputB, carry out to CF.
  - 1 XOR.
  - 2 AND.
  - 3 ROL: rotate inputA left by inputB[SHW-1:0].
  - 4 SLL.
  - 5 ROR.
  - 6 SRL: logical.
  - 7 BTR: bit reverse of inputA.
  - 8 SEQ: inputA==inputB.
  - 9 SLT: signed A<B on raw A,B.
  - 10 SLE: signed A<=B on raw A,B.
  - 11 SCO: carry out of inputA+inputB.
  - 12 MUL: low WIDTH bits of unsigned inputA*inputB.
  - 13-15: ADD (13 is MULH when enabled; see Optional Feature).
  - Compare modes output 0 or 1, zero-extended to WIDTH.
- Flags, captured with out:
  - ZF = (out==0).
  - SF = out[WIDTH-1].
  - CF = adder carry for ADD/SCO, 0 otherwise.
  - OF: signed overflow of the adder if (invA|invB)&c_in, else the unsigned carry. Meaningful for ADD only, 0 for other modes.
- Handshake:
  - Accept occurs when in_valid & in_ready.
  - in_ready = (state==IDLE) & (~out_valid | out_ready).
  - Results hold stable while out_valid & ~out_ready.
- FSM states: IDLE, MUL, HOLD.
  - IDLE, accept of a non-MUL op: out/flags registered next edge, out_valid=1, stay in IDLE. Latency is 1 cycle, throughput is 1/cycle when out_ready=1.
  - IDLE, accept of MUL: latch inputA and inputB, clear the 2*WIDTH product accumulator and the counter, busy=1, go to MUL.
  - MUL: one bit per cycle for WIDTH cycles. Then load out/flags, set out_valid=1, busy=0, go to HOLD. Result appears WIDTH+1 cycles after accept.
  - HOLD: when out_ready=1, go to IDLE. out_valid drops the same edge unless a new accept occurs (which is only possible from IDLE, so out_valid drops).
  - In IDLE, if out_valid and out_ready are high together with a new accept, the new result replaces the old one with no bubble.
  - out_ready is ignored while out_valid=0.
- Boundaries:
  - Shift amount of 0 returns inputA unchanged.
  - MUL by 0 returns 0 with ZF=1.
  - inputs asserted while busy are ignored (in_ready=0).

Optional Feature:
- Macro ALU_MC_MULH_EN.
- Defined: mode 13 = MULH, the high WIDTH bits of the same iterative product, with the same FSM and latency.
- Undefined: mode 13 behaves as ADD; the accumulator is only WIDTH bits and its upper half is removed.

Test Plan:
- ADD, WIDTH=16, A=0x7FFF, B=0x0001, inv=0 -> out=0x8000, SF=1, ZF=0, CF=0, OF=0 (unsigned rule); one cycle latency.
- SUB via invB=1, c_in=1, A=0x0005, B=0x0005 -> out=0x0000, ZF=1, CF=1; SEQ with the same operands -> out=0x0001.
- Shift/rotate: A=0x8001, B=0x0001:
  - ROL -> 0x0003.
  - ROR -> 0xC000.
  - SRL -> 0x4000.
  - BTR A=0x0001 -> 0x8000.
  - SLT A=0xFFFF, B=0x0001 -> 0x0001.
- MUL A=0x0012, B=0x0034 -> busy for 16 cycles, in_ready=0; out=0x03A8 at cycle 17; with MULH_EN, mode 13 on 0xFFFF*0xFFFF -> 0xFFFE.
- Back-pressure: result held with out_ready=0 for 5 cycles -> out and flags stable, in_ready=0; then out_ready=1 together with a new ADD accept -> back-to-back results.
- Assert rst_n=0 at multiply cycle 8 -> out_valid=0, busy=0, out=0 immediately; the first op after reset completes normally.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: handshaked EX-stage ALU with registered result/flags and an iterative shift-add multiplier.
// Optional: define ALU_MC_MULH_EN to make mode 13 return the high half of the product (MULH).
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             invA,
    input  logic             invB,
    input  logic             c_in,
    input  logic [3:0]       alu_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             ZF,
    output logic             SF,
    output logic             OF,
    output logic             CF,
    output logic             busy
);

`ifdef ALU_MC_MULH_EN
    localparam int PW      = 2 * WIDTH;
    localparam bit MULH_ON = 1'b1;
`else
    localparam int PW      = WIDTH;
    localparam bit MULH_ON = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_HOLD = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             zf_q, zf_d, sf_q, sf_d, of_q, of_d, cf_q, cf_d;
    logic             out_valid_q, out_valid_d, busy_q, busy_d, hi_q, hi_d;
    logic [PW-1:0]    mcand_q, mcand_d, acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0] ia_s, ib_s, rol_s, ror_s, res_s, prod_s;
    logic [SHW-1:0]   sh_s;
    logic [WIDTH:0]   sum_s;
    logic [PW-1:0]    acc_step_s;
    logic             sub_s, sov_s, add_of_s, cf_s, of_s, is_mul_s, is_mulh_s, accept_s;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

    assign ia_s     = invA ? (~A + {{(WIDTH-1){1'b0}}, c_in}) : A;
    assign ib_s     = invB ? (~B + {{(WIDTH-1){1'b0}}, c_in}) : B;
    assign sh_s     = ib_s[SHW-1:0];
    assign sum_s    = {1'b0, ia_s} + {1'b0, ib_s};
    assign sub_s    = (invA | invB) & c_in;
    assign sov_s    = (ia_s[WIDTH-1] == ib_s[WIDTH-1]) & (sum_s[WIDTH-1] != ia_s[WIDTH-1]);
    assign add_of_s = sub_s ? sov_s : sum_s[WIDTH];
    // A shift of WIDTH yields zero, so a zero shift amount leaves the rotate equal to ia_s.
    assign rol_s    = (ia_s << sh_s) | (ia_s >> (WIDTH - int'(sh_s)));
    assign ror_s    = (ia_s >> sh_s) | (ia_s << (WIDTH - int'(sh_s)));

    assign accept_s   = in_valid & in_ready;
    assign acc_step_s = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign prod_s     = hi_q ? acc_step_s[PW-1 -: WIDTH] : acc_step_s[WIDTH-1:0];

    // Single-cycle operation decode and flag generation.
    always_comb begin
        res_s     = sum_s[WIDTH-1:0];
        cf_s      = 1'b0;
        of_s      = 1'b0;
        is_mul_s  = 1'b0;
        is_mulh_s = 1'b0;
        case (alu_mode)
            4'd1:  res_s = ia_s ^ ib_s;
            4'd2:  res_s = ia_s & ib_s;
            4'd3:  res_s = rol_s;
            4'd4:  res_s = ia_s << sh_s;
            4'd5:  res_s = ror_s;
            4'd6:  res_s = ia_s >> sh_s;
            4'd7:  res_s = bit_rev(ia_s);
            4'd8:  res_s = {{(WIDTH-1){1'b0}}, ia_s == ib_s};
            4'd9:  res_s = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            4'd10: res_s = {{(WIDTH-1){1'b0}}, $signed(A) <= $signed(B)};
            4'd11: begin
                res_s = {{(WIDTH-1){1'b0}}, sum_s[WIDTH]};
                cf_s  = sum_s[WIDTH];
            end
            4'd12: is_mul_s = 1'b1;
            4'd13: begin
                if (MULH_ON) begin
                    is_mul_s  = 1'b1;
                    is_mulh_s = 1'b1;
                end else begin
                    cf_s = sum_s[WIDTH];
                    of_s = add_of_s;
                end
            end
            default: begin
                cf_s = sum_s[WIDTH];
                of_s = add_of_s;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE) & (~out_valid_q | out_ready);
    assign out       = out_q;
    assign ZF        = zf_q;
    assign SF        = sf_q;
    assign OF        = of_q;
    assign CF        = cf_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

    // Next-state logic for the IDLE/MUL/HOLD controller and the multiplier datapath.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        zf_d        = zf_q;
        sf_d        = sf_q;
        of_d        = of_q;
        cf_d        = cf_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        hi_d        = hi_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s && is_mul_s) begin
                    mcand_d     = PW'(ia_s);
                    mplier_d    = ib_s;
                    acc_d       = '0;
                    cnt_d       = '0;
                    hi_d        = is_mulh_s;
                    busy_d      = 1'b1;
                    out_valid_d = 1'b0;
                    state_d     = S_MUL;
                end else if (accept_s) begin
                    out_d       = res_s;
                    zf_d        = (res_s == '0);
                    sf_d        = res_s[WIDTH-1];
                    of_d        = of_s;
                    cf_d        = cf_s;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
            end
            S_MUL: begin
                acc_d    = acc_step_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    out_d       = prod_s;
                    zf_d        = (prod_s == '0);
                    sf_d        = prod_s[WIDTH-1];
                    of_d        = 1'b0;
                    cf_d        = 1'b0;
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_HOLD;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_q       <= '0;
            zf_q        <= 1'b0;
            sf_q        <= 1'b0;
            of_q        <= 1'b0;
            cf_q        <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            hi_q        <= 1'b0;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            zf_q        <= zf_d;
            sf_q        <= sf_d;
            of_q        <= of_d;
            cf_q        <= cf_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            hi_q        <= hi_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vector table, multi-cycle sequences and random ops against a reference model.
module tb_alu_mc;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, invA, invB, c_in, out_valid, out_ready;
    logic          ZF, SF, OF, CF, busy;
    logic [W-1:0]  A, B, out;
    logic [3:0]    alu_mode;
    int            checks = 0;
    int            errors = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .invA(invA), .invB(invB), .c_in(c_in), .alu_mode(alu_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .ZF(ZF), .SF(SF), .OF(OF), .CF(CF), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a, b;
        logic        na, nb, c;
        logic [3:0]  m;
        logic [15:0] eo;
        logic [3:0]  ef;
        logic        mul;
    } vec_t;

    typedef struct {
        logic [15:0] o;
        logic [3:0]  f;
        logic        mul;
    } exp_t;

    function automatic int to_signed(longint unsigned v);
        return (v >= 64'd32768) ? int'(v) - 65536 : int'(v);
    endfunction

    // Reference model from the operation definitions, using wide integer arithmetic.
    function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic na, logic nb,
                                   logic c, logic [3:0] m);
        exp_t e;
        longint unsigned la, lb, ia, ib, s, r, msk;
        int sa, sb, sh;
        bit carry, ovf, sub, is_add, is_sco;
        msk = 64'hFFFF;
        la = a;
        lb = b;
        ia = na ? ((~la + c) & msk) : la;
        ib = nb ? ((~lb + c) & msk) : lb;
        s = ia + ib;
        carry = s[16];
        sa = to_signed(ia);
        sb = to_signed(ib);
        ovf = (sa + sb > 32767) || (sa + sb < -32768);
        sub = (na | nb) & c;
        sh = int'(ib % 64'd16);
        is_add = 1'b0;
        is_sco = 1'b0;
        e.mul = 1'b0;
        r = 64'd0;
        case (m)
            4'd1:  r = ia ^ ib;
            4'd2:  r = ia & ib;
            4'd3:  r = ((ia << sh) | (ia >> (16 - sh))) & msk;
            4'd4:  r = (ia << sh) & msk;
            4'd5:  r = ((ia >> sh) | (ia << (16 - sh))) & msk;
            4'd6:  r = ia >> sh;
            4'd7:  for (int i = 0; i < 16; i++) if (((ia >> i) & 64'd1) != 64'd0) r = r | (64'd1 << (15 - i));
            4'd8:  r = (ia == ib) ? 64'd1 : 64'd0;
            4'd9:  r = (to_signed(la) < to_signed(lb)) ? 64'd1 : 64'd0;
            4'd10: r = (to_signed(la) <= to_signed(lb)) ? 64'd1 : 64'd0;
            4'd11: begin r = carry; is_sco = 1'b1; end
            4'd12: begin r = (ia * ib) & msk; e.mul = 1'b1; end
`ifdef ALU_MC_MULH_EN
            4'd13: begin r = ((ia * ib) >> 16) & msk; e.mul = 1'b1; end
`endif
            default: begin r = s & msk; is_add = 1'b1; end
        endcase
        e.o = r[15:0];
        e.f = {r[15:0] == 16'd0, r[15], is_add & (sub ? ovf : carry), (is_add | is_sco) & carry};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) chk({nm, "_ready_timeout"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Issue one op, wait for its result, check latency and result/flags.
    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic na,
                         input logic nb, input logic c, input logic [3:0] m,
                         input logic [15:0] eo, input logic [3:0] ef, input logic mul,
                         input string nm);
        int lat;
        wait_ready(nm);
        A = a; B = b; invA = na; invB = nb; c_in = c; alu_mode = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        if (mul) chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, mul ? W + 1 : 1);
        chk({nm, "_result"}, {12'd0, out, ZF, SF, OF, CF}, {12'd0, eo, ef});
    endtask

    vec_t vecs[$];
    exp_t e;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; invA = 1'b0; invB = 1'b0;
        c_in = 1'b0; alu_mode = 4'd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {10'd0, out, ZF, SF, OF, CF, out_valid, busy}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // Flags are {ZF,SF,OF,CF}.
        vecs.push_back('{16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd0,  16'h8000, 4'b0100, 1'b0});
        vecs.push_back('{16'h0005, 16'h0005, 1'b0, 1'b1, 1'b1, 4'd0,  16'h0000, 4'b1001, 1'b0});
        vecs.push_back('{16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0, 4'd8,  16'h0001, 4'b0000, 1'b0});
        vecs.push_back('{16'h8001, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd3,  16'h0003, 4'b0000, 1'b0});
        vecs.push_back('{16'h8001, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd5,  16'hC000, 4'b0100, 1'b0});
        vecs.push_back('{16'h8001, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd6,  16'h4000, 4'b0000, 1'b0});
        vecs.push_back('{16'h8001, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd4,  16'h0002, 4'b0000, 1'b0});
        vecs.push_back('{16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd7,  16'h8000, 4'b0100, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd9,  16'h0001, 4'b0000, 1'b0});
        vecs.push_back('{16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd9,  16'h0000, 4'b1000, 1'b0});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 4'd10, 16'h0001, 4'b0000, 1'b0});
        vecs.push_back('{16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd3,  16'h1234, 4'b0000, 1'b0});
        vecs.push_back('{16'h1234, 16'h0010, 1'b0, 1'b0, 1'b0, 4'd5,  16'h1234, 4'b0000, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd11, 16'h0001, 4'b0001, 1'b0});
        vecs.push_back('{16'hF0F0, 16'hFF00, 1'b0, 1'b0, 1'b0, 4'd1,  16'h0FF0, 4'b0000, 1'b0});
        vecs.push_back('{16'hF0F0, 16'hFF00, 1'b0, 1'b0, 1'b0, 4'd2,  16'hF000, 4'b0100, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0002, 1'b0, 1'b0, 1'b0, 4'd0,  16'h0001, 4'b0011, 1'b0});
        vecs.push_back('{16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 4'd0,  16'h7FFF, 4'b0011, 1'b0});
        vecs.push_back('{16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 4'd15, 16'h0002, 4'b0000, 1'b0});
        vecs.push_back('{16'h0012, 16'h0034, 1'b0, 1'b0, 1'b0, 4'd12, 16'h03A8, 4'b0000, 1'b1});
        vecs.push_back('{16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 4'd12, 16'h0000, 4'b1000, 1'b1});
`ifdef ALU_MC_MULH_EN
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 4'd13, 16'hFFFE, 4'b0100, 1'b1});
`else
        vecs.push_back('{16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 4'd13, 16'h0003, 4'b0000, 1'b0});
`endif
        foreach (vecs[i]) begin
            apply(vecs[i].a, vecs[i].b, vecs[i].na, vecs[i].nb, vecs[i].c, vecs[i].m,
                  vecs[i].eo, vecs[i].ef, vecs[i].mul, $sformatf("vec%0d", i));
        end

        // Multiply with new requests presented while busy: they must be refused.
        wait_ready("mulseq");
        A = 16'h0012; B = 16'h0034; invA = 1'b0; invB = 1'b0; c_in = 1'b0;
        alu_mode = 4'd12; in_valid = 1'b1;
        @(posedge clk); #1;
        alu_mode = 4'd0; A = 16'h0001; B = 16'h0001;
        for (int i = 0; i < 14; i++) begin
            chk($sformatf("mul_stall%0d", i), {30'd0, busy, in_ready}, 32'd2);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        begin
            int n;
            n = 0;
            while (out_valid !== 1'b1 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            chk("mul_tail_cycles", n, 2);
        end
        chk("mul_result", {12'd0, out, ZF, SF, OF, CF}, {12'd0, 16'h03A8, 4'b0000});
        chk("mul_busy_done", {31'd0, busy}, 32'd0);

        // Back-pressure: result held, then released together with a new accept.
        wait_ready("bp");
        out_ready = 1'b0;
        A = 16'h1111; B = 16'h2222; alu_mode = 4'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        A = 16'h0001; B = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i), {8'd0, out, ZF, SF, OF, CF, out_valid, in_ready},
                {8'd0, 16'h3333, 4'b0000, 1'b1, 1'b0});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_release", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("bp_next1", {11'd0, out, out_valid}, {11'd0, 16'h0002, 1'b1});
        A = 16'h0003; B = 16'h0004;
        @(posedge clk); #1;
        chk("bp_next2", {11'd0, out, out_valid}, {11'd0, 16'h0007, 1'b1});
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_drain", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a multiply.
        wait_ready("rstseq");
        A = 16'h0012; B = 16'h0034; alu_mode = 4'd12; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_state", {10'd0, out, ZF, SF, OF, CF, out_valid, busy}, 32'd0);
        @(posedge clk); #4;
        rst_n = 1'b1;
        apply(16'h0100, 16'h0023, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0123, 4'b0000, 1'b0, "after_reset");

        // Random operations against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic [15:0] ra, rb;
            logic        rna, rnb, rc;
            logic [3:0]  rm;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rna = 1'($urandom_range(0, 1));
            rnb = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            rm = 4'($urandom_range(0, 15));
            e = model(ra, rb, rna, rnb, rc, rm);
            apply(ra, rb, rna, rnb, rc, rm, e.o, e.f, e.mul, $sformatf("rnd%0d_m%0d", i, rm));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
